pll_reset_sequencer: RTL and testbench

//   Consumes the PLL 'locked' status and generates the staged, synchronous, active-low

---
 rtl/pll_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronizes pll_locked, waits for stable lock, then releases the
// SDRAM-side reset ahead of the system reset. Any loss of lock re-asserts both resets
// together, and losses from STAGGER or RUN are counted.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 16,
    parameter int unsigned HOLD_CYCLES        = 8,
    parameter int unsigned CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             sdram_rst_n,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             loss_pulse,
    output logic [CNT_W-1:0] loss_count
);

    // One shared counter sized for the longest interval; it only ever reaches N-1.
    localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                                      LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int unsigned CTR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CTR_W-1:0] HOLD_LAST    = CTR_W'(HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0] STABLE_LAST  = CTR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] STAGGER_LAST = CTR_W'(STAGGER_CYCLES - 1);

    typedef enum logic [2:0] {
        StHold,
        StWait,
        StStable,
        StStagger,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CTR_W-1:0]       ctr_q, ctr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   counted_loss;

    logic                   sdram_rst_n_q, sdram_rst_n_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   loss_pulse_q, loss_pulse_d;
    logic [CNT_W-1:0]       loss_count_q, loss_count_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // pll_locked synchronizer; cleared by reset so lock is re-qualified from scratch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        counted_loss = 1'b0;
        loss_count_d = loss_count_q;

        unique case (state_q)
            StHold: begin
                if (ctr_q == HOLD_LAST) state_d = StWait;
            end
            StWait: begin
                if (locked_s) state_d = StStable;
            end
            StStable: begin
                // A drop here is a lock glitch: restart, but do not count it.
                if (!locked_s) begin
                    state_d = StHold;
                end else if (ctr_q == STABLE_LAST) begin
                    state_d = StStagger;
                end
            end
            StStagger: begin
                if (!locked_s) begin
                    state_d      = StHold;
                    counted_loss = 1'b1;
                end else if (ctr_q == STAGGER_LAST) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d      = StHold;
                    counted_loss = 1'b1;
                end
            end
            default: state_d = StHold;
        endcase

        // Counter restarts on every state entry; it is idle in WAIT and RUN.
        if (state_d != state_q || state_q == StWait || state_q == StRun) begin
            ctr_d = '0;
        end else begin
            ctr_d = ctr_q + CTR_W'(1);
        end

        loss_pulse_d = counted_loss;
        if (counted_loss && (loss_count_q != {CNT_W{1'b1}})) begin
            loss_count_d = loss_count_q + CNT_W'(1);
        end

        // Reset outputs are a pure function of the next state, so they move only on transitions.
        sdram_rst_n_d = (state_d == StStagger) || (state_d == StRun);
        sys_rst_n_d   = (state_d == StRun);
        ready_d       = (state_d == StRun);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StHold;
            ctr_q         <= '0;
            sdram_rst_n_q <= 1'b0;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            loss_pulse_q  <= 1'b0;
            loss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            sdram_rst_n_q <= sdram_rst_n_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            loss_pulse_q  <= loss_pulse_d;
            loss_count_q  <= loss_count_d;
        end
    end

    assign sdram_rst_n = sdram_rst_n_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign loss_pulse  = loss_pulse_q;
    assign loss_count  = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: cold-start vector table plus directed
// sequences for late lock, STABLE glitch, loss in RUN, saturation and mid-STAGGER reset.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sdram_rst_n;
    logic       sys_rst_n;
    logic       ready;
    logic       loss_pulse;
    logic [1:0] loss_count;

    int n_checks = 0;
    int n_errors = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .STAGGER_CYCLES    (4),
        .HOLD_CYCLES       (3),
        .CNT_W             (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sdram_rst_n(sdram_rst_n),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .loss_pulse (loss_pulse),
        .loss_count (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {sdram_rst_n, sys_rst_n, ready, loss_pulse, loss_count}
    logic [5:0] outs;
    assign outs = {sdram_rst_n, sys_rst_n, ready, loss_pulse, loss_count};

    typedef struct {
        logic       rst;
        logic       lk;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic lk);
        rst        = 1'b0;
        pll_locked = lk;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Ticks until sys_rst_n rises; reports the tick index of each release and pulses seen.
    task automatic measure_release(input int bound, output int t_sdram, output int t_sys,
                                   output int pulses);
        t_sdram = -1;
        t_sys   = -1;
        pulses  = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (loss_pulse === 1'b1) pulses++;
            if (sdram_rst_n === 1'b1 && t_sdram < 0) t_sdram = i;
            if (sys_rst_n === 1'b1) begin
                t_sys = i;
                break;
            end
        end
    endtask

    // Drops pll_locked and checks the reaction, including one cycle after the pulse.
    task automatic lose_lock(input string tag, input int exp_cnt);
        int t;
        pll_locked = 1'b0;
        t = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (sdram_rst_n === 1'b0) begin
                t = i;
                break;
            end
        end
        check({tag, " loss latency"}, t, 3);
        check({tag, " sys_rst_n on loss"}, {31'd0, sys_rst_n}, 0);
        check({tag, " ready on loss"}, {31'd0, ready}, 0);
        check({tag, " loss_pulse on loss"}, {31'd0, loss_pulse}, 1);
        check({tag, " loss_count"}, {30'd0, loss_count}, exp_cnt);
        tick();
        check({tag, " loss_pulse width"}, {31'd0, loss_pulse}, 0);
    endtask

    task automatic relock(input string tag, input int exp_sdram, input int exp_sys,
                          input int exp_cnt);
        int ts, ty, np;
        pll_locked = 1'b1;
        measure_release(40, ts, ty, np);
        check({tag, " sdram release tick"}, ts, exp_sdram);
        check({tag, " sys release tick"}, ty, exp_sys);
        check({tag, " pulses during release"}, np, 0);
        check({tag, " ready in run"}, {31'd0, ready}, 1);
        check({tag, " loss_count after release"}, {30'd0, loss_count}, exp_cnt);
    endtask

    initial begin
        int ts, ty, np, busy, t;

        rst        = 1'b0;
        pll_locked = 1'b1;

        // Test 1: cold start. Two reset cycles; HOLD 3, sync 2, WAIT 1, STABLE 8 -> sdram
        // rises on the 12th edge with rst=1, sys/ready 4 edges later.
        for (int i = 0; i < 20; i++) begin
            vecs[i].rst = (i >= 2);
            vecs[i].lk  = 1'b1;
            if (i < 13)      vecs[i].exp = 6'b000000;
            else if (i < 17) vecs[i].exp = 6'b100000;
            else             vecs[i].exp = 6'b111000;
        end
        for (int i = 0; i < 20; i++) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].lk;
            tick();
            check($sformatf("cold row %0d outs", i), {26'd0, outs}, {26'd0, vecs[i].exp});
        end

        // Test 2: late lock, 50 cycles unlocked. From pll_locked=1: 2 sync + 1 WAIT + 8.
        do_reset(1'b0);
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (outs !== 6'b000000) busy++;
        end
        check("late lock idle outputs", busy, 0);
        relock("late lock", 11, 15, 0);

        // Test 3: one-cycle glitch late in STABLE restarts via HOLD, uncounted.
        do_reset(1'b1);
        repeat (8) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        measure_release(40, ts, ty, np);
        check("glitch sdram release tick", ts, 14);
        check("glitch sys release tick", ty, 18);
        check("glitch loss_pulse count", np, 0);
        check("glitch loss_count", {30'd0, loss_count}, 0);

        // Test 4: loss in RUN, then staged release repeats.
        lose_lock("run loss", 1);
        relock("run relock", 11, 15, 1);

        // Test 5: saturation of the 2-bit counter over five losses from RUN.
        do_reset(1'b1);
        measure_release(40, ts, ty, np);
        check("sat initial sdram tick", ts, 12);
        check("sat initial sys tick", ty, 16);
        for (int k = 0; k < 5; k++) begin
            lose_lock($sformatf("sat %0d", k), (k < 2) ? k + 1 : 3);
            relock($sformatf("sat %0d", k), 11, 15, (k < 2) ? k + 1 : 3);
        end

        // Test 6: rst mid-STAGGER clears everything, including the saturated count.
        lose_lock("stagger prep", 3);
        pll_locked = 1'b1;
        t = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sdram_rst_n === 1'b1) begin
                t = i;
                break;
            end
        end
        check("stagger entry tick", t, 11);
        tick();
        tick();
        check("mid stagger sys_rst_n", {31'd0, sys_rst_n}, 0);
        rst = 1'b0;
        tick();
        check("mid stagger reset outs", {26'd0, outs}, 0);
        rst = 1'b1;
        measure_release(40, ts, ty, np);
        check("post reset sdram tick", ts, 12);
        check("post reset sys tick", ty, 16);
        check("post reset pulses", np, 0);
        check("post reset loss_count", {30'd0, loss_count}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
